// File: rtl/cfg_chain_loader.sv
// Configuration-chain loader: serialises bitstream words LSB-first onto prog_in/prog_en
// and optionally recirculates the chain to compare CRC-16 of loaded and read-back bits.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 4480,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 13
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int SH_W    = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  state_t            state;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              hold_vld, hold_vld_d;
  logic [SH_W-1:0]   sh_cnt, sh_cnt_d;
  logic [CNT_W-1:0]  words, words_d;
  logic [CNT_W-1:0]  bit_cnt_inc;
  logic              verify_lat;
  logic              prog_in_q;
  logic [15:0]       crc_load, crc_read, crc_read_nxt;
  logic              accept, can_issue, have_bit, nxt_bit, issue, last_shift;
  logic [CNT_W:0]    issued;

  assign accept       = s_valid & s_ready;
  // Bits already committed to the chain, including the one on prog_in this cycle.
  assign issued       = {1'b0, bit_cnt} + {{CNT_W{1'b0}}, prog_en};
  assign can_issue    = (state == ST_LOAD) && (issued < (CNT_W + 1)'(CHAIN_LEN));
  assign last_shift   = prog_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign bit_cnt_inc  = (bit_cnt == CNT_W'(CHAIN_LEN)) ? bit_cnt : bit_cnt + CNT_W'(1);
  assign crc_read_nxt = crc16_step(crc_read, prog_out);
  // Recirculation needs the tail on the head in the same cycle, so this path is combinational.
  assign prog_in      = (state == ST_VERIFY) ? prog_out : prog_in_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    have_bit   = 1'b0;
    nxt_bit    = 1'b0;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt;
    hold_d     = hold_q;
    hold_vld_d = hold_vld;
    words_d    = words + CNT_W'(accept);

    if (sh_cnt != '0) begin
      have_bit = 1'b1;
      nxt_bit  = sh_q[0];
    end else if (hold_vld) begin
      have_bit = 1'b1;
      nxt_bit  = hold_q[0];
    end else if (accept) begin
      have_bit = 1'b1;
      nxt_bit  = s_data[0];
    end
    issue = can_issue && have_bit;

    if (issue) begin
      if (sh_cnt != '0) begin
        sh_d     = sh_q >> 1;
        sh_cnt_d = sh_cnt - SH_W'(1);
      end else if (hold_vld) begin
        sh_d       = hold_q >> 1;
        sh_cnt_d   = SH_W'(WORD_W - 1);
        hold_vld_d = 1'b0;
      end else begin
        sh_d     = s_data >> 1;
        sh_cnt_d = SH_W'(WORD_W - 1);
      end
    end

    // A word bypasses the holding register only when it feeds an empty shifter directly.
    if (accept && !(issue && (sh_cnt == '0) && !hold_vld)) begin
      hold_d     = s_data;
      hold_vld_d = 1'b1;
    end
  end

  // NOTE: word data registers are not reset; hold_vld and sh_cnt qualify their contents.
  always_ff @(posedge prog_clk) begin
    if (state == ST_LOAD) begin
      hold_q <= hold_d;
      sh_q   <= sh_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge prog_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b0;
      prog_en    <= 1'b0;
      prog_in_q  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      bit_cnt    <= '0;
      words      <= '0;
      hold_vld   <= 1'b0;
      sh_cnt     <= '0;
      verify_lat <= 1'b0;
      crc_load   <= 16'hFFFF;
      crc_read   <= 16'hFFFF;
    end else if (abort) begin
      state     <= ST_ERROR;
      s_ready   <= 1'b0;
      prog_en   <= 1'b0;
      prog_in_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b1;
      hold_vld  <= 1'b0;
      sh_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LOAD;
            verify_lat <= verify_en;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            bit_cnt    <= '0;
            words      <= '0;
            hold_vld   <= 1'b0;
            sh_cnt     <= '0;
            crc_load   <= 16'hFFFF;
            crc_read   <= 16'hFFFF;
          end
        end

        ST_LOAD: begin
          if (prog_en) crc_load <= crc16_step(crc_load, prog_in_q);
          if (last_shift) begin
            // Leftover high bits of the final word are dropped with the flush.
            prog_en   <= verify_lat;
            prog_in_q <= 1'b0;
            s_ready   <= 1'b0;
            hold_vld  <= 1'b0;
            sh_cnt    <= '0;
            if (verify_lat) begin
              state   <= ST_VERIFY;
              bit_cnt <= '0;
            end else begin
              state   <= ST_DONE;
              bit_cnt <= bit_cnt_inc;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            if (prog_en) bit_cnt <= bit_cnt_inc;
            prog_en   <= issue;
            prog_in_q <= issue & nxt_bit;
            sh_cnt    <= sh_cnt_d;
            hold_vld  <= hold_vld_d;
            words     <= words_d;
            s_ready   <= !hold_vld_d && (words_d < CNT_W'(N_WORDS));
          end
        end

        ST_VERIFY: begin
          if (prog_en) begin
            crc_read <= crc_read_nxt;
            bit_cnt  <= bit_cnt_inc;
            if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
              prog_en <= 1'b0;
              busy    <= 1'b0;
              if (crc_read_nxt == crc_load) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_ERROR;
                err   <= 1'b1;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: random bitstreams against a 4480-bit chain model and a
// flattened LSB-first expected bit sequence.
module tb_cfg_chain_loader;

  localparam int L         = 4480;
  localparam int W         = 32;
  localparam int CW        = 13;
  localparam int NW        = 140;
  localparam int FAULT_BIT = 1234;

  logic          prog_clk;
  logic          rst, start, verify_en, abort;
  logic [W-1:0]  s_data;
  logic          s_valid, s_ready;
  logic          prog_in, prog_en, prog_out;
  logic          busy, done, err;
  logic [CW-1:0] bit_cnt;

  cfg_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(CW)) dut (
    .prog_clk (prog_clk),
    .rst      (rst),
    .start    (start),
    .verify_en(verify_en),
    .abort    (abort),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .prog_in  (prog_in),
    .prog_en  (prog_en),
    .prog_out (prog_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bit_cnt  (bit_cnt)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int compared   = 0;
  int mismatched = 0;

  // Chain model: circular buffer whose oldest entry is the tail.
  logic chain [L];
  int   ptr = 0;
  assign prog_out = chain[ptr];

  int       cyc = 0;
  int       en_cnt, restarts, last_en, first_en, first_acc, bad_in, over_cnt, acc_n;
  bit       prev_en, fault_arm, pend, pend_b, pend_flip;
  bit       load_bits[$];
  logic [W-1:0] word_q[$];
  int       stall_after = -1, stall_len = 0, stall_cnt = 0;

  initial for (int i = 0; i < L; i++) chain[i] = 1'b0;

  always @(negedge prog_clk) begin
    pend      = prog_en;
    pend_b    = prog_in;
    pend_flip = 1'b0;
    if (prog_en) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc + 1;
      if (!prev_en && en_cnt > 1) restarts++;
      last_en = cyc + 1;
      if (en_cnt <= L) load_bits.push_back(prog_in);
      if (en_cnt == L && fault_arm) pend_flip = 1'b1;
    end
    if (!prog_en && prog_in) bad_in++;
    if (bit_cnt > CW'(L)) over_cnt++;
    prev_en = prog_en;
  end

  always @(posedge prog_clk) begin
    cyc++;
    if (pend) begin
      chain[ptr] <= pend_b;
      ptr        <= (ptr + 1) % L;
      if (pend_flip) chain[(ptr + 1 + FAULT_BIT) % L] <= ~chain[(ptr + 1 + FAULT_BIT) % L];
    end
  end

  // Word source: presents the queue head, optionally pausing after a given accepted word.
  initial begin
    bit hs;
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge prog_clk);
      if (word_q.size() > 0 && stall_cnt == 0) begin
        s_valid = 1'b1;
        s_data  = word_q[0];
      end else begin
        s_valid = 1'b0;
        if (stall_cnt > 0) stall_cnt--;
      end
      hs = s_valid && s_ready;
      if (hs && first_acc < 0) first_acc = cyc + 1;
      @(posedge prog_clk);
      if (hs && word_q.size() > 0) begin
        void'(word_q.pop_front());
        acc_n++;
        if (acc_n == stall_after) stall_cnt = stall_len;
      end
    end
  end

  task automatic clear_mon();
    en_cnt = 0; restarts = 0; last_en = -1; first_en = -1; first_acc = -1;
    bad_in = 0; over_cnt = 0; acc_n = 0; prev_en = 1'b0; fault_arm = 1'b0;
    stall_after = -1; stall_len = 0; stall_cnt = 0;
    load_bits.delete();
  endtask

  task automatic pulse_start(input bit ver);
    @(negedge prog_clk);
    start = 1'b1; verify_en = ver;
    @(negedge prog_clk);
    start = 1'b0; verify_en = 1'b0;
  endtask

  task automatic wait_bit_cnt(input string name, input int target);
    int c;
    for (c = 0; c < 2000 && bit_cnt != CW'(target); c++) @(negedge prog_clk);
    compared++;
    if (bit_cnt != CW'(target)) begin
      mismatched++;
      $display("FAIL %s wait_bit_cnt: got %0d want %0d", name, bit_cnt, target);
    end
  endtask

  task automatic run_pass(input string name, input bit ver, input bit fault,
                          input int st_after, input int st_len, input bit poke_start);
    logic [W-1:0] words [NW];
    int seen, lbad, cbad, want_en;
    bit expb;
    for (int i = 0; i < NW; i++) words[i] = $urandom;
    @(negedge prog_clk);
    clear_mon();
    fault_arm = fault; stall_after = st_after; stall_len = st_len;
    for (int i = 0; i < NW; i++) word_q.push_back(words[i]);
    pulse_start(ver);
    seen = -1;
    for (int c = 0; c < 30000; c++) begin
      start     = poke_start && (c == 300);
      verify_en = poke_start && (c == 300);
      if (done || err) begin seen = cyc; break; end
      @(negedge prog_clk);
    end
    start = 1'b0; verify_en = 1'b0;
    #1;
    lbad = (load_bits.size() == L) ? 0 : 1;
    cbad = 0;
    for (int i = 0; i < L; i++) begin
      expb = words[i / W][i % W];
      if (i < load_bits.size() && load_bits[i] !== expb) lbad++;
      if (chain[(ptr + i) % L] !== (expb ^ (fault && i == FAULT_BIT))) cbad++;
    end
    want_en = ver ? 2 * L : L;

    compared++; if (seen < 0) begin mismatched++; $display("FAIL %s timeout: got no done/err want done/err", name); end
    compared++; if (done !== !fault) begin mismatched++; $display("FAIL %s done: got %0b want %0b", name, done, !fault); end
    compared++; if (err !== fault) begin mismatched++; $display("FAIL %s err: got %0b want %0b", name, err, fault); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL %s busy: got %0b want 0", name, busy); end
    compared++; if (en_cnt != want_en) begin mismatched++; $display("FAIL %s shift_count: got %0d want %0d", name, en_cnt, want_en); end
    compared++; if (lbad != 0) begin mismatched++; $display("FAIL %s load_bits: got %0d bad want 0", name, lbad); end
    compared++; if (cbad != 0) begin mismatched++; $display("FAIL %s chain_contents: got %0d bad want 0", name, cbad); end
    compared++; if (seen != last_en) begin mismatched++; $display("FAIL %s done_latency: got edge %0d want %0d", name, seen, last_en); end
    compared++; if (bit_cnt !== CW'(L)) begin mismatched++; $display("FAIL %s bit_cnt: got %0d want %0d", name, bit_cnt, L); end
    compared++; if (first_en != first_acc + 1) begin mismatched++; $display("FAIL %s first_shift: got edge %0d want %0d", name, first_en, first_acc + 1); end
    compared++; if (bad_in != 0) begin mismatched++; $display("FAIL %s idle_prog_in: got %0d want 0", name, bad_in); end
    compared++; if (word_q.size() != 0) begin mismatched++; $display("FAIL %s words_left: got %0d want 0", name, word_q.size()); end
    if (st_len == 0) begin
      compared++; if (restarts != 0) begin mismatched++; $display("FAIL %s contiguous: got %0d gaps want 0", name, restarts); end
    end else if (st_len > 2 * W) begin
      compared++; if (restarts == 0) begin mismatched++; $display("FAIL %s underflow_gap: got 0 gaps want >0", name); end
    end
    repeat (5) @(negedge prog_clk);
    compared++; if (bit_cnt !== CW'(L) || prog_en !== 1'b0 || s_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL %s hold_after: got cnt=%0d en=%0b rdy=%0b want cnt=%0d en=0 rdy=0", name, bit_cnt, prog_en, s_ready, L);
    end
    compared++; if (over_cnt != 0) begin mismatched++; $display("FAIL %s saturate: got %0d over want 0", name, over_cnt); end
  endtask

  task automatic check_reset_outputs(input string name);
    compared++;
    if ({s_ready, prog_en, prog_in, busy, done, err} !== 6'b0 || bit_cnt !== '0) begin
      mismatched++;
      $display("FAIL %s reset_outputs: got rdy=%0b en=%0b in=%0b busy=%0b done=%0b err=%0b cnt=%0d want all 0",
               name, s_ready, prog_en, prog_in, busy, done, err, bit_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; verify_en = 1'b0; abort = 1'b0;
    clear_mon();
    repeat (3) @(negedge prog_clk);
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_ignored_valid();
    for (int i = 0; i < 3; i++) word_q.push_back($urandom);
    repeat (5) @(negedge prog_clk);
    compared++; if (word_q.size() != 3) begin mismatched++; $display("FAIL idle_valid consumed: got %0d left want 3", word_q.size()); end
    compared++; if (prog_en !== 1'b0 || s_ready !== 1'b0) begin mismatched++; $display("FAIL idle_valid outputs: got en=%0b rdy=%0b want 0 0", prog_en, s_ready); end
    word_q.delete();
  endtask

  task automatic test_abort();
    @(negedge prog_clk);
    clear_mon();
    for (int i = 0; i < NW; i++) word_q.push_back($urandom);
    pulse_start(1'b0);
    wait_bit_cnt("abort", 100);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    word_q.delete();
    compared++; if (prog_en !== 1'b0 || s_ready !== 1'b0) begin mismatched++; $display("FAIL abort outputs: got en=%0b rdy=%0b want 0 0", prog_en, s_ready); end
    compared++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL abort status: got err=%0b done=%0b busy=%0b want 1 0 0", err, done, busy); end
    // abort wins over a simultaneous start
    @(negedge prog_clk);
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    compared++; if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin mismatched++; $display("FAIL abort_priority: got err=%0b busy=%0b rdy=%0b want 1 0 0", err, busy, s_ready); end
    run_pass("after_abort", 1'b0, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_rst_mid_load();
    @(negedge prog_clk);
    clear_mon();
    for (int i = 0; i < NW; i++) word_q.push_back($urandom);
    pulse_start(1'b1);
    wait_bit_cnt("rst_mid", 500);
    rst = 1'b1;
    @(negedge prog_clk);
    word_q.delete();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    @(negedge prog_clk);
    check_reset_outputs("rst_mid_idle");
  endtask

  initial begin
    test_reset();
    test_ignored_valid();
    run_pass("continuous", 1'b0, 1'b0, -1, 0, 1'b0);
    run_pass("stall_short", 1'b0, 1'b0, 5, 10, 1'b0);
    run_pass("stall_long_start_busy", 1'b0, 1'b0, 5, 80, 1'b1);
    run_pass("verify_pass", 1'b1, 1'b0, -1, 0, 1'b0);
    run_pass("verify_fault", 1'b1, 1'b1, -1, 0, 1'b0);
    test_abort();
    test_rst_mid_load();
    run_pass("verify_after_rst", 1'b1, 1'b0, 3, 40, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
